// File: rtl/spi_result_reporter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_result_reporter
// Purpose  : Round-robin SPI master shipping per-channel result words to one
//            slave each, with optional readback-and-compare frame.
// Revision : 1.0
// ============================================================================
module spi_result_reporter #(
    parameter int SLAVE_COUNT                = 3,
    parameter int DATA_WIDTH                 = 16,
    parameter int SCLK_RATIO                 = 10,
    parameter int SLAVE_REQUIRED_HIGH_CYCLES = 1,
    parameter int SYNC_FLOPS                 = 2,
    parameter int READBACK                   = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [SLAVE_COUNT-1:0]            result_valid,
    input  logic [SLAVE_COUNT*DATA_WIDTH-1:0] result_data,
    output logic [SLAVE_COUNT-1:0]            result_ready,
    output logic                              spi_sclk,
    output logic                              spi_mosi,
    input  logic                              spi_miso,
    output logic [SLAVE_COUNT-1:0]            spi_ss_out,
    output logic                              busy,
    output logic [SLAVE_COUNT-1:0]            frame_done,
    output logic [SLAVE_COUNT-1:0]            echo_mismatch
);
    localparam int c_H       = SCLK_RATIO / 2;
    localparam int c_GAP     = SLAVE_REQUIRED_HIGH_CYCLES * SCLK_RATIO;
    localparam int c_CNT_MAX = (c_GAP > c_H) ? c_GAP : c_H;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);
    localparam int c_PW      = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;
    localparam int c_BW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_SHIFT_HI = 3'd2,
        S_SHIFT_LO = 3'd3,
        S_HOLD     = 3'd4,
        S_GAP      = 3'd5
    } state_t;

    state_t                  r_state;
    logic [c_CW-1:0]         r_cnt;
    logic [c_BW-1:0]         r_bit;
    logic [c_PW-1:0]         r_rr_ptr;
    logic [c_PW-1:0]         r_sel;
    logic                    r_rd;
    logic [DATA_WIDTH-1:0]   r_word;
    logic [DATA_WIDTH-1:0]   r_tx;
    logic [DATA_WIDTH-1:0]   r_rx;
    logic [SLAVE_COUNT-1:0]  r_ready;
    logic [SLAVE_COUNT-1:0]  r_ss;
    logic [SLAVE_COUNT-1:0]  r_done;
    logic [SLAVE_COUNT-1:0]  r_echo;
    logic                    r_sclk;
    logic                    r_mosi;
    logic                    r_busy;

    logic                    w_found;
    logic [c_PW-1:0]         w_win;
    logic [c_PW-1:0]         w_next_ptr;
    logic [c_PW:0]           w_sum;
    logic [SLAVE_COUNT-1:0]  w_win_oh;
    logic [SLAVE_COUNT-1:0]  w_sel_oh;
    logic [DATA_WIDTH-1:0]   w_din;
    logic [DATA_WIDTH-1:0]   w_tx_next;
    logic                    w_miso_s;

    // Scan downward so the candidate closest to r_rr_ptr is written last and wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = SLAVE_COUNT - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (c_PW + 1)'(k);
            if (w_sum >= (c_PW + 1)'(SLAVE_COUNT)) begin
                w_sum = w_sum - (c_PW + 1)'(SLAVE_COUNT);
            end
            if (result_valid[w_sum[c_PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[c_PW-1:0];
            end
        end
    end

    always_comb begin
        w_next_ptr = (w_win == c_PW'(SLAVE_COUNT - 1)) ? '0 : w_win + 1'b1;
        w_win_oh = '0;
        w_win_oh[w_win] = 1'b1;
        w_sel_oh = '0;
        w_sel_oh[r_sel] = 1'b1;
        w_din     = result_data[w_win*DATA_WIDTH +: DATA_WIDTH];
        w_tx_next = r_tx << 1;
    end

    generate
        if (SYNC_FLOPS > 1) begin : g_sync_multi
            logic [SYNC_FLOPS-1:0] r_sync;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_sync <= '0;
                else       r_sync <= {r_sync[SYNC_FLOPS-2:0], spi_miso};
            end
            assign w_miso_s = r_sync[SYNC_FLOPS-1];
        end else begin : g_sync_single
            logic r_sync;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_sync <= 1'b0;
                else       r_sync <= spi_miso;
            end
            assign w_miso_s = r_sync;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_rr_ptr <= '0;
            r_sel    <= '0;
            r_rd     <= 1'b0;
            r_word   <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_ready  <= '0;
            r_ss     <= '1;
            r_done   <= '0;
            r_echo   <= '0;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_ready <= '0;
            r_done  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_ready  <= w_win_oh;
                        r_busy   <= 1'b1;
                        r_sel    <= w_win;
                        r_rr_ptr <= w_next_ptr;
                        r_word   <= w_din;
                        r_tx     <= w_din;
                        r_mosi   <= w_din[DATA_WIDTH-1];
                        r_rd     <= 1'b0;
                        r_bit    <= '0;
                        // One extra count: the grant cycle itself keeps SS high.
                        r_cnt    <= c_CW'(c_H);
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_ss <= ~w_sel_oh;
                    if (r_cnt == '0) begin
                        r_sclk  <= 1'b1;
                        r_cnt   <= c_CW'(c_H - 1);
                        r_state <= S_SHIFT_HI;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SHIFT_HI: begin
                    if (r_cnt == '0) begin
                        r_sclk  <= 1'b0;
                        r_tx    <= w_tx_next;
                        r_mosi  <= r_rd ? 1'b0 : w_tx_next[DATA_WIDTH-1];
                        if (r_rd) begin
                            r_rx <= {r_rx[DATA_WIDTH-2:0], w_miso_s};
                        end
                        r_cnt   <= c_CW'(c_H - 1);
                        r_state <= S_SHIFT_LO;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SHIFT_LO: begin
                    if (r_cnt == '0) begin
                        r_cnt <= c_CW'(c_H - 1);
                        if (r_bit == c_BW'(DATA_WIDTH - 1)) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_sclk  <= 1'b1;
                            r_bit   <= r_bit + 1'b1;
                            r_state <= S_SHIFT_HI;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == '0) begin
                        r_ss    <= '1;
                        r_mosi  <= 1'b0;
                        r_cnt   <= c_CW'(c_GAP - 1);
                        r_state <= S_GAP;
                        if (r_rd && (r_rx != r_word)) begin
                            r_echo[r_sel] <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        if ((READBACK != 0) && !r_rd) begin
                            r_rd    <= 1'b1;
                            r_ss    <= ~w_sel_oh;
                            r_tx    <= r_word;
                            r_bit   <= '0;
                            r_mosi  <= 1'b0;
                            r_cnt   <= c_CW'(c_H - 1);
                            r_state <= S_SETUP;
                        end else begin
                            r_done  <= w_sel_oh;
                            r_busy  <= 1'b0;
                            r_mosi  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign result_ready  = r_ready;
    assign spi_sclk      = r_sclk;
    assign spi_mosi      = r_mosi;
    assign spi_ss_out    = r_ss;
    assign busy          = r_busy;
    assign frame_done    = r_done;
    assign echo_mismatch = r_echo;

endmodule
`default_nettype wire
